// File: rtl/pspin_pkt_dma_her_pkg.sv
// Shared encodings and default widths for the packet DMA / HER issue block.
package pspin_pkt_dma_her_pkg;

    localparam int DEF_ADDR_WIDTH   = 32;
    localparam int DEF_LEN_WIDTH    = 20;
    localparam int DEF_MSGID_WIDTH  = 10;
    localparam int DEF_MAX_INFLIGHT = 16;
    localparam int DEF_TAG_WIDTH    = 8;

    typedef enum logic [1:0] {
        TAG_FREE   = 2'd0,
        TAG_ISSUED = 2'd1,
        TAG_DONE   = 2'd2
    } tag_state_e;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_HER_OUT  = 2'd1,
        ST_FREE_OUT = 2'd2
    } out_state_e;

    function automatic logic [31:0] sat_inc(input logic [31:0] v);
        return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
    endfunction

endpackage

// File: rtl/pspin_pkt_dma_her_if.sv
// Handshake bundle between allocator/matcher, DMA engine, PsPIN and the HER block.
interface pspin_pkt_dma_her_if
    import pspin_pkt_dma_her_pkg::*;
#(
    parameter int ADDR_WIDTH  = DEF_ADDR_WIDTH,
    parameter int LEN_WIDTH   = DEF_LEN_WIDTH,
    parameter int MSGID_WIDTH = DEF_MSGID_WIDTH,
    parameter int TAG_WIDTH   = DEF_TAG_WIDTH
);
    logic [ADDR_WIDTH-1:0]  alloc_addr_i;
    logic [LEN_WIDTH-1:0]   alloc_len_i;
    logic                   alloc_valid_i;
    logic                   alloc_ready_o;

    logic [LEN_WIDTH-1:0]   meta_len_i;
    logic [MSGID_WIDTH-1:0] meta_msgid_i;
    logic                   meta_eom_i;
    logic                   meta_valid_i;
    logic                   meta_ready_o;

    logic [ADDR_WIDTH-1:0]  dma_addr_o;
    logic [LEN_WIDTH-1:0]   dma_len_o;
    logic [TAG_WIDTH-1:0]   dma_tag_o;
    logic                   dma_valid_o;
    logic                   dma_ready_i;

    logic [TAG_WIDTH-1:0]   dma_status_tag_i;
    logic                   dma_status_error_i;
    logic                   dma_status_valid_i;

    logic [ADDR_WIDTH-1:0]  her_addr_o;
    logic [LEN_WIDTH-1:0]   her_size_o;
    logic [LEN_WIDTH-1:0]   her_xfer_size_o;
    logic [MSGID_WIDTH-1:0] her_msgid_o;
    logic                   her_eom_o;
    logic                   her_valid_o;
    logic                   her_ready_i;

    logic [ADDR_WIDTH-1:0]  free_addr_o;
    logic [LEN_WIDTH-1:0]   free_size_o;
    logic                   free_valid_o;
    logic                   free_ready_i;

    modport slave (
        input  alloc_addr_i, alloc_len_i, alloc_valid_i,
        output alloc_ready_o,
        input  meta_len_i, meta_msgid_i, meta_eom_i, meta_valid_i,
        output meta_ready_o,
        output dma_addr_o, dma_len_o, dma_tag_o, dma_valid_o,
        input  dma_ready_i,
        input  dma_status_tag_i, dma_status_error_i, dma_status_valid_i,
        output her_addr_o, her_size_o, her_xfer_size_o, her_msgid_o, her_eom_o, her_valid_o,
        input  her_ready_i,
        output free_addr_o, free_size_o, free_valid_o,
        input  free_ready_i
    );

    modport master (
        output alloc_addr_i, alloc_len_i, alloc_valid_i,
        input  alloc_ready_o,
        output meta_len_i, meta_msgid_i, meta_eom_i, meta_valid_i,
        input  meta_ready_o,
        input  dma_addr_o, dma_len_o, dma_tag_o, dma_valid_o,
        output dma_ready_i,
        output dma_status_tag_i, dma_status_error_i, dma_status_valid_i,
        input  her_addr_o, her_size_o, her_xfer_size_o, her_msgid_o, her_eom_o, her_valid_o,
        output her_ready_i,
        input  free_addr_o, free_size_o, free_valid_o,
        output free_ready_i
    );

endinterface

// File: rtl/pspin_her_cpl_fifo.sv
// Completion tag FIFO: a push is visible on valid_o one cycle later; depth covers every tag.
module pspin_her_cpl_fifo #(
    parameter int DEPTH = 16,
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push_i,
    input  logic [WIDTH-1:0] data_i,
    input  logic             pop_i,
    output logic             valid_o,
    output logic [WIDTH-1:0] data_o
);
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [PW-1:0] PTR_ONE = 1;
    localparam logic [PW:0]   CNT_ONE = 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];
    logic [PW-1:0]    wptr_q, wptr_d, rptr_q, rptr_d;
    logic [PW:0]      cnt_q, cnt_d;
    logic             do_pop;

    always_comb begin
        mem_d  = mem_q;
        wptr_d = wptr_q;
        rptr_d = rptr_q;
        cnt_d  = cnt_q;
        do_pop = pop_i && (cnt_q != '0);
        if (push_i) begin
            mem_d[wptr_q] = data_i;
            wptr_d        = wptr_q + PTR_ONE;
        end
        if (do_pop) rptr_d = rptr_q + PTR_ONE;
        case ({push_i, do_pop})
            2'b10:   cnt_d = cnt_q + CNT_ONE;
            2'b01:   cnt_d = cnt_q - CNT_ONE;
            default: cnt_d = cnt_q;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
            wptr_q <= '0;
            rptr_q <= '0;
            cnt_q  <= '0;
        end else begin
            mem_q  <= mem_d;
            wptr_q <= wptr_d;
            rptr_q <= rptr_d;
            cnt_q  <= cnt_d;
        end
    end

    assign valid_o = (cnt_q != '0);
    assign data_o  = mem_q[rptr_q];

endmodule

// File: rtl/pspin_pkt_dma_her.sv
// Joins allocator slots with packet metadata, issues tagged DMA writes and turns
// completions into handler execution requests (or slot returns on DMA error).
module pspin_pkt_dma_her
    import pspin_pkt_dma_her_pkg::*;
#(
    parameter int ADDR_WIDTH   = DEF_ADDR_WIDTH,
    parameter int LEN_WIDTH    = DEF_LEN_WIDTH,
    parameter int MSGID_WIDTH  = DEF_MSGID_WIDTH,
    parameter int MAX_INFLIGHT = DEF_MAX_INFLIGHT,
    parameter int TAG_WIDTH    = DEF_TAG_WIDTH
) (
    input  logic               clk,
    input  logic               rstn,
    pspin_pkt_dma_her_if.slave bus,
    output logic [TAG_WIDTH:0] inflight_o,
    output logic [31:0]        dma_err_count_o,
    output logic [31:0]        spurious_count_o
);
    localparam int IW = $clog2(MAX_INFLIGHT);
    localparam logic [TAG_WIDTH:0] CNT_ONE = 1;

    // Async assert, synchronous release of the internal reset.
    logic [1:0] rst_sync_q, rst_sync_d;
    logic       rst_n;

    always_comb rst_sync_d = {rst_sync_q[0], 1'b1};

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) rst_sync_q <= '0;
        else       rst_sync_q <= rst_sync_d;
    end

    assign rst_n = rst_sync_q[1];

    tag_state_e             tag_st_q  [MAX_INFLIGHT];
    tag_state_e             tag_st_d  [MAX_INFLIGHT];
    logic [ADDR_WIDTH-1:0]  ent_addr_q  [MAX_INFLIGHT];
    logic [ADDR_WIDTH-1:0]  ent_addr_d  [MAX_INFLIGHT];
    logic [LEN_WIDTH-1:0]   ent_size_q  [MAX_INFLIGHT];
    logic [LEN_WIDTH-1:0]   ent_size_d  [MAX_INFLIGHT];
    logic [LEN_WIDTH-1:0]   ent_xfer_q  [MAX_INFLIGHT];
    logic [LEN_WIDTH-1:0]   ent_xfer_d  [MAX_INFLIGHT];
    logic [MSGID_WIDTH-1:0] ent_msgid_q [MAX_INFLIGHT];
    logic [MSGID_WIDTH-1:0] ent_msgid_d [MAX_INFLIGHT];
    logic [MAX_INFLIGHT-1:0] ent_eom_q, ent_eom_d, ent_err_q, ent_err_d;

    logic                  dma_valid_q, dma_valid_d;
    logic [ADDR_WIDTH-1:0] dma_addr_q, dma_addr_d;
    logic [LEN_WIDTH-1:0]  dma_len_q, dma_len_d;
    logic [TAG_WIDTH-1:0]  dma_tag_q, dma_tag_d;
    logic [31:0]           spur_cnt_q, spur_cnt_d;

    out_state_e             state_q;
    logic                   her_valid_q, free_valid_q;
    logic [IW-1:0]          out_tag_q;
    logic [ADDR_WIDTH-1:0]  out_addr_q;
    logic [LEN_WIDTH-1:0]   out_size_q, out_xfer_q;
    logic [MSGID_WIDTH-1:0] out_msgid_q;
    logic                   out_eom_q;
    logic [31:0]            err_cnt_q;

    logic                 free_found, issue;
    logic [IW-1:0]        free_idx, st_tag, fifo_tag;
    logic [LEN_WIDTH-1:0] xfer;
    logic                 st_in_range, cpl_ok, spurious, release_tag;
    logic                 fifo_valid, fifo_pop;
    logic [TAG_WIDTH:0]   inflight_cnt;

    always_comb begin
        free_found = 1'b0;
        free_idx   = '0;
        for (int i = MAX_INFLIGHT - 1; i >= 0; i--) begin
            if (tag_st_q[i] == TAG_FREE) begin
                free_found = 1'b1;
                free_idx   = IW'(i);
            end
        end
        // Both sides are consumed together; a free tag and an open descriptor slot are required.
        issue = bus.alloc_valid_i && bus.meta_valid_i && free_found &&
                (!dma_valid_q || bus.dma_ready_i);
        xfer  = (bus.meta_len_i < bus.alloc_len_i) ? bus.meta_len_i : bus.alloc_len_i;

        st_tag      = bus.dma_status_tag_i[IW-1:0];
        st_in_range = ((bus.dma_status_tag_i >> IW) == '0);
        cpl_ok      = bus.dma_status_valid_i && st_in_range && (tag_st_q[st_tag] == TAG_ISSUED);
        spurious    = bus.dma_status_valid_i && !cpl_ok;

        release_tag = ((state_q == ST_HER_OUT)  && bus.her_ready_i) ||
                      ((state_q == ST_FREE_OUT) && bus.free_ready_i);
        fifo_pop    = (state_q == ST_IDLE);
    end

    always_comb begin
        tag_st_d    = tag_st_q;
        ent_addr_d  = ent_addr_q;
        ent_size_d  = ent_size_q;
        ent_xfer_d  = ent_xfer_q;
        ent_msgid_d = ent_msgid_q;
        ent_eom_d   = ent_eom_q;
        ent_err_d   = ent_err_q;
        dma_valid_d = dma_valid_q;
        dma_addr_d  = dma_addr_q;
        dma_len_d   = dma_len_q;
        dma_tag_d   = dma_tag_q;
        spur_cnt_d  = spurious ? sat_inc(spur_cnt_q) : spur_cnt_q;

        // Release, completion and issue always target distinct tags by construction.
        if (release_tag) tag_st_d[out_tag_q] = TAG_FREE;
        if (cpl_ok) begin
            tag_st_d[st_tag]  = TAG_DONE;
            ent_err_d[st_tag] = bus.dma_status_error_i;
        end

        if (dma_valid_q && bus.dma_ready_i) dma_valid_d = 1'b0;
        if (issue) begin
            tag_st_d[free_idx]    = TAG_ISSUED;
            ent_addr_d[free_idx]  = bus.alloc_addr_i;
            ent_size_d[free_idx]  = bus.alloc_len_i;
            ent_xfer_d[free_idx]  = xfer;
            ent_msgid_d[free_idx] = bus.meta_msgid_i;
            ent_eom_d[free_idx]   = bus.meta_eom_i;
            ent_err_d[free_idx]   = 1'b0;
            dma_valid_d           = 1'b1;
            dma_addr_d            = bus.alloc_addr_i;
            dma_len_d             = xfer;
            dma_tag_d             = TAG_WIDTH'(free_idx);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < MAX_INFLIGHT; i++) begin
                tag_st_q[i]    <= TAG_FREE;
                ent_addr_q[i]  <= '0;
                ent_size_q[i]  <= '0;
                ent_xfer_q[i]  <= '0;
                ent_msgid_q[i] <= '0;
            end
            ent_eom_q   <= '0;
            ent_err_q   <= '0;
            dma_valid_q <= 1'b0;
            dma_addr_q  <= '0;
            dma_len_q   <= '0;
            dma_tag_q   <= '0;
            spur_cnt_q  <= '0;
        end else begin
            tag_st_q    <= tag_st_d;
            ent_addr_q  <= ent_addr_d;
            ent_size_q  <= ent_size_d;
            ent_xfer_q  <= ent_xfer_d;
            ent_msgid_q <= ent_msgid_d;
            ent_eom_q   <= ent_eom_d;
            ent_err_q   <= ent_err_d;
            dma_valid_q <= dma_valid_d;
            dma_addr_q  <= dma_addr_d;
            dma_len_q   <= dma_len_d;
            dma_tag_q   <= dma_tag_d;
            spur_cnt_q  <= spur_cnt_d;
        end
    end

    pspin_her_cpl_fifo #(
        .DEPTH (MAX_INFLIGHT),
        .WIDTH (IW)
    ) u_cpl_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .push_i  (cpl_ok),
        .data_i  (st_tag),
        .pop_i   (fifo_pop),
        .valid_o (fifo_valid),
        .data_o  (fifo_tag)
    );

    // Output FSM: one completed tag at a time, in completion order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            her_valid_q  <= 1'b0;
            free_valid_q <= 1'b0;
            out_tag_q    <= '0;
            out_addr_q   <= '0;
            out_size_q   <= '0;
            out_xfer_q   <= '0;
            out_msgid_q  <= '0;
            out_eom_q    <= 1'b0;
            err_cnt_q    <= '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (fifo_valid) begin
                        out_tag_q   <= fifo_tag;
                        out_addr_q  <= ent_addr_q[fifo_tag];
                        out_size_q  <= ent_size_q[fifo_tag];
                        out_xfer_q  <= ent_xfer_q[fifo_tag];
                        out_msgid_q <= ent_msgid_q[fifo_tag];
                        out_eom_q   <= ent_eom_q[fifo_tag];
                        if (ent_err_q[fifo_tag]) begin
                            state_q      <= ST_FREE_OUT;
                            free_valid_q <= 1'b1;
                            err_cnt_q    <= sat_inc(err_cnt_q);
                        end else begin
                            state_q     <= ST_HER_OUT;
                            her_valid_q <= 1'b1;
                        end
                    end
                end
                ST_HER_OUT: begin
                    if (bus.her_ready_i) begin
                        her_valid_q <= 1'b0;
                        state_q     <= ST_IDLE;
                    end
                end
                ST_FREE_OUT: begin
                    if (bus.free_ready_i) begin
                        free_valid_q <= 1'b0;
                        state_q      <= ST_IDLE;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    always_comb begin
        inflight_cnt = '0;
        for (int i = 0; i < MAX_INFLIGHT; i++) begin
            if (tag_st_q[i] != TAG_FREE) inflight_cnt = inflight_cnt + CNT_ONE;
        end
    end

    assign bus.alloc_ready_o   = issue;
    assign bus.meta_ready_o    = issue;
    assign bus.dma_valid_o     = dma_valid_q;
    assign bus.dma_addr_o      = dma_addr_q;
    assign bus.dma_len_o       = dma_len_q;
    assign bus.dma_tag_o       = dma_tag_q;
    assign bus.her_valid_o     = her_valid_q;
    assign bus.her_addr_o      = out_addr_q;
    assign bus.her_size_o      = out_size_q;
    assign bus.her_xfer_size_o = out_xfer_q;
    assign bus.her_msgid_o     = out_msgid_q;
    assign bus.her_eom_o       = out_eom_q;
    assign bus.free_valid_o    = free_valid_q;
    assign bus.free_addr_o     = out_addr_q;
    assign bus.free_size_o     = out_size_q;
    assign inflight_o          = inflight_cnt;
    assign dma_err_count_o     = err_cnt_q;
    assign spurious_count_o    = spur_cnt_q;

endmodule

// File: doc/pspin_pkt_dma_her.md
Name: pspin_pkt_dma_her

Overview:
- Sits directly downstream of the PsPIN packet allocator.
- Joins each allocated L2 slot (addr, slot size) with the matching engine's packet metadata (true length, msgid, eom), assigns a DMA tag and issues an AXI DMA write descriptor.
- Tracks in-flight writes by tag. On DMA write completion it emits a handler execution request (HER) to PsPIN.
- On DMA error it returns the slot on a free port, which is arbitrated into the allocator feedback path.

Parameters:
- ADDR_WIDTH, 32, L2 address width.
- LEN_WIDTH, 20, length width.
- MSGID_WIDTH, 10, message id width.
- MAX_INFLIGHT, 16, outstanding DMA writes; power of 2, ≥2.
- TAG_WIDTH, 8, DMA tag width; must be ≥ $clog2(MAX_INFLIGHT). Tags used are 0..MAX_INFLIGHT-1, zero-extended.

Ports:
- clk  in  1  clock.
- rstn  in  1  reset, asynchronous, active-low.
- alloc_addr_i / alloc_len_i / alloc_valid_i / alloc_ready_o  in/in/in/out  ADDR_WIDTH/LEN_WIDTH/1/1  slot from allocator; alloc_len_i is the slot size.
- meta_len_i / meta_msgid_i / meta_eom_i / meta_valid_i / meta_ready_o  in/in/in/in/out  LEN_WIDTH/MSGID_WIDTH/1/1/1  packet metadata.
- dma_addr_o / dma_len_o / dma_tag_o / dma_valid_o / dma_ready_i  out/out/out/out/in  ADDR_WIDTH/LEN_WIDTH/TAG_WIDTH/1/1  DMA write descriptor.
- dma_status_tag_i / dma_status_error_i / dma_status_valid_i  in/in/in  TAG_WIDTH/1/1  write completion; no backpressure.
- her_addr_o / her_size_o / her_xfer_size_o / her_msgid_o / her_eom_o / her_valid_o / her_ready_i  out×6/in  ADDR_WIDTH/LEN_WIDTH/LEN_WIDTH/MSGID_WIDTH/1/1/1  HER to PsPIN.
- free_addr_o / free_size_o / free_valid_o / free_ready_i  out/out/out/in  ADDR_WIDTH/LEN_WIDTH/1/1  slot return on error.
- inflight_o  out  TAG_WIDTH+1  count of tags not FREE.
- dma_err_count_o / spurious_count_o  out  32 each  saturating counters.

Behaviour:
- Reset (async assert, sync deassert inside block):
  - All valids low.
  - All data outputs zero.
  - Counters zero.
  - Every tag FREE.
  - FSM in IDLE.
  - Completion FIFO empty.
- Per-tag state: FREE, ISSUED, DONE. Table entry per tag holds addr, slot size, xfer size, msgid, eom, error.
- Issue:
  - Fire when alloc_valid_i && meta_valid_i && a FREE tag exists (registered bitmap) && (!dma_valid_o || dma_ready_i).
  - On fire, alloc_ready_o and meta_ready_o are both high in the same cycle; neither ready is ever high alone.
  - Tag chosen = lowest-index FREE tag; it becomes ISSUED.
  - dma_* outputs are registered, valid the next cycle, and held stable until dma_ready_i.
- Length rules:
  - xfer = min(meta_len_i, alloc_len_i); dma_len_o = xfer.
  - meta_len_i 0 is issued as length 0; the DMA engine still returns status.
- Completion:
  - Status in cycle N for an ISSUED tag: tag → DONE, error bit stored, tag pushed into completion FIFO in N.
  - Status for a FREE or DONE tag: ignored, spurious_count_o +1.
  - FIFO depth MAX_INFLIGHT, so overflow is impossible.
- Output FSM:
  - IDLE: if FIFO non-empty (visible N+1), pop and load output registers from the table.
    - No error → HER_OUT, her_valid_o high in N+2.
    - Error → FREE_OUT, free_valid_o high in N+2, dma_err_count_o +1.
  - HER_OUT: hold outputs until her_ready_i; then tag → FREE, go to IDLE.
  - FREE_OUT: hold outputs until free_ready_i; then tag → FREE, go to IDLE.
  - her_size_o and free_size_o = slot size; her_xfer_size_o = xfer.
  - One HER or free per 2 cycles max. Order follows completion order, not issue order.
- Simultaneous events:
  - Issue, completion and tag release may coincide in one cycle.
  - A tag released in cycle N is allocatable from N+1 only.
  - inflight_o reflects the registered bitmap.
- Reset mid-operation: all state is discarded. Late DMA statuses after reset hit FREE tags and count as spurious.

Decomposition:
- Package pspin_pkt_dma_her_pkg:
  - Tag-state encoding (FREE=0, ISSUED=1, DONE=2).
  - FSM state encoding.
  - Default widths.
- Sub-module pspin_her_cpl_fifo: tag FIFO, registered output, 1-cycle push-to-valid latency, depth MAX_INFLIGHT.

Test Plan:
- Single packet: alloc 0x1c400000/1536, meta len 1000 msgid 3 eom 1 → dma_valid_o next cycle (len 1000, tag 0). Status tag 0 ok in cycle N → HER in N+2 (addr 0x1c400000, size 1536, xfer 1000, msgid 3, eom 1); inflight_o returns to 0.
- Tag exhaustion: 16 issues with no status → alloc_ready_o low and inflight_o=16. Status tag 5 → HER accepted → the next issue uses tag 5.
- Out-of-order completion: tags 0,1,2 issued; statuses 2,0,1 → HERs in order 2,0,1 with the correct per-tag fields.
- Error path: status tag 0 with error=1 → no HER; free_valid_o with addr/size 1536; dma_err_count_o=1. Hold free_ready_i low 5 cycles → outputs stable throughout.
- Spurious and backpressure: status on a FREE tag → spurious_count_o=1, no output. dma_ready_i low 10 cycles → descriptor held stable, alloc_ready_o low. meta_len 2000 with slot 1536 → dma_len_o 1536.
- Async reset asserted with 3 tags in flight → all outputs zero immediately. After release, statuses for those tags → spurious_count_o=3.
